dmem_responder: RTL and testbench

- Data-memory responder for the core's load/store port: the target end of the valid/ready data bus that the processor drives as initiator.
- Accepts one request at a time. Applies a programmable number of wait states. Performs a byte-lane masked write or a full-word read on an internal word array. Returns one response per request under backpressure.
- Sits between the core data port and on-chip RAM. Used to exercise and verify multi-cycle memory latency.

---
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready target with programmable wait states,
// byte-lane masked stores and full-word loads. Optional DMEM_ERR_EN adds range/alignment errors.
module dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        mem_q [DEPTH];

    logic [IDX_W-1:0]   acc_idx;
    logic               acc_err;
    logic               mem_we;
    logic [31:0]        mem_wr_word;

    // Replace only the enabled byte lanes of the stored word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef DMEM_ERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    logic [31:0] acc_offset;

    always_comb begin
        acc_offset = addr_q - ADDR_BASE;
        acc_idx    = IDX_W'(acc_offset >> 2);
        acc_err    = ({1'b0, acc_offset} >= SPAN) || (addr_q[1:0] != 2'b00);
    end
`else
    // Out-of-range offsets wrap onto the array by dropping upper index bits.
    always_comb begin
        acc_idx = IDX_W'((addr_q - ADDR_BASE) >> 2);
        acc_err = 1'b0;
    end
`endif

    assign mem_wr_word = merge_lanes(mem_q[acc_idx], wdata_q, be_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    state_d     = RESP;
                    if (we_q) begin
                        rsp_rdata_d = 32'h0;
                        mem_we      = !acc_err;
                    end else begin
                        rsp_rdata_d = acc_err ? 32'h0 : mem_q[acc_idx];
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents are cleared by reset so a dropped store leaves no trace.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= mem_wr_word;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a main instance (WAIT_CYCLES=2) and a
// zero-wait instance for latency. Error expectations follow DMEM_ERR_EN.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] model [256];
    int          accept_cyc;
    bit          got_ok;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_cyc;

    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a >= 32'h0000_0400) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'h0000_00FF);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Drive one request on the main instance and push its expected response.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   idx;
        int   n;
        e.err = model_err(addr);
        idx   = model_idx(addr);
        if (we) begin
            e.rdata = 32'h0;
            if (!e.err) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end else begin
            e.rdata = e.err ? 32'h0 : model[idx];
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            total++;
        end
        accept_cyc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        req_we    = 1'($urandom);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        got_ok = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        if (rsp_valid) begin
            got_ok    = 1'b1;
            got_rdata = rsp_rdata;
            got_err   = rsp_err;
            got_cyc   = cyc;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            $display("FAIL reset_in: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            $display("FAIL reset_out: ready=%b valid=%b rdata=%h required 1 0 0",
                     req_ready, rsp_valid, rsp_rdata);
        end else passed++;
        total++;
        if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_err !== 1'b0) begin
            $display("FAIL reset_dut0: ready=%b valid=%b err=%b required 1 0 0",
                     z_req_ready, z_rsp_valid, z_rsp_err);
        end else passed++;
    endtask

    task automatic test_store_load();
        exp_t e;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata || got_err !== e.err) begin
            $display("FAIL store_rsp: ok=%0d rdata=%h err=%b required %h %b", got_ok, got_rdata, got_err, e.rdata, e.err);
        end else passed++;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata) begin
            $display("FAIL load_rdata: ok=%0d rdata=%h required %h", got_ok, got_rdata, e.rdata);
        end else passed++;
        total++;
        if (got_err !== 1'b0) begin
            $display("FAIL load_err: err=%b required 0", got_err);
        end else passed++;
    endtask

    task automatic test_byte_lanes();
        exp_t e;
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
        wait_valid(); ack();
        void'(exp_q.pop_front());
        issue(1'b1, 32'h20, 32'h00000000, 4'b0101);
        wait_valid(); ack();
        void'(exp_q.pop_front());
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata || e.rdata !== 32'hFF00FF00) begin
            $display("FAIL lane_merge: rdata=%h required %h", got_rdata, e.rdata);
        end else passed++;
        issue(1'b1, 32'h20, 32'h12345678, 4'b0000);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== 32'h0 || got_err !== e.err) begin
            $display("FAIL be0_rsp: ok=%0d rdata=%h err=%b required 0 %b", got_ok, got_rdata, got_err, e.err);
        end else passed++;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata) begin
            $display("FAIL be0_nowrite: rdata=%h required %h", got_rdata, e.rdata);
        end else passed++;
    endtask

    task automatic test_latency();
        exp_t e;
        int   n;
        int   z_acc;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_cyc !== accept_cyc + 3) begin
            $display("FAIL latency_w2: valid after edge %0d required %0d", got_cyc, accept_cyc + 3);
        end else passed++;
        total++;
        if (got_rdata !== e.rdata) begin
            $display("FAIL latency_w2_data: rdata=%h required %h", got_rdata, e.rdata);
        end else passed++;

        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_we    = 1'b0;
        z_req_addr  = 32'h0;
        z_acc       = cyc + 1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!z_rsp_valid && n < 20);
        total++;
        if (!z_rsp_valid || cyc !== z_acc + 1 || z_rsp_rdata !== 32'h0) begin
            $display("FAIL latency_w0: valid=%b edge %0d rdata=%h required 1 %0d 0",
                     z_rsp_valid, cyc, z_rsp_rdata, z_acc + 1);
        end else passed++;
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        z_rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_valid();
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
                $display("FAIL stall_%0d: valid=%b rdata=%h ready=%b required 1 %h 0",
                         i, rsp_valid, rsp_rdata, req_ready, e.rdata);
            end else passed++;
        end
        ack();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL after_ack: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end else passed++;
        issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        wait_valid(); ack();
        void'(exp_q.pop_front());
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata) begin
            $display("FAIL next_req: rdata=%h required %h", got_rdata, e.rdata);
        end else passed++;
    endtask

    task automatic test_range();
        exp_t e;
        issue(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        wait_valid(); ack();
        void'(exp_q.pop_front());
        issue(1'b0, 32'h400, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata || got_err !== e.err) begin
            $display("FAIL load_0x400: rdata=%h err=%b required %h %b", got_rdata, got_err, e.rdata, e.err);
        end else passed++;
        issue(1'b1, 32'h402, 32'h11111111, 4'hF);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== 32'h0 || got_err !== e.err) begin
            $display("FAIL store_0x402: rdata=%h err=%b required 0 %b", got_rdata, got_err, e.err);
        end else passed++;
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata || got_err !== 1'b0) begin
            $display("FAIL word0_after: rdata=%h err=%b required %h 0", got_rdata, got_err, e.rdata);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(1'b1, 32'h8, 32'h12345678, 4'hF);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL mid_reset_hold: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end else passed++;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            $display("FAIL mid_reset_release: ready=%b valid=%b rdata=%h required 1 0 0",
                     req_ready, rsp_valid, rsp_rdata);
        end else passed++;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        wait_valid(); ack();
        e = exp_q.pop_front();
        total++;
        if (!got_ok || got_rdata !== e.rdata || e.rdata !== 32'h0) begin
            $display("FAIL dropped_store: rdata=%h required %h", got_rdata, e.rdata);
        end else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_be      = 4'h0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = 32'h0;
        z_req_wdata = 32'h0;
        z_req_be    = 4'h0;
        z_rsp_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_latency();
        test_backpressure();
        test_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
